// File: rtl/tpu_skew_feeder.sv
// ============================================================================
//  Module   : tpu_skew_feeder
//  Brief    : Operand staging buffer that captures a DIM x DIM matrix row by
//             row and streams it diagonally skewed into a systolic MAC edge.
//             Build macro TPU_SKEW_TRANSPOSE_EN streams stored columns instead.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tpu_skew_feeder #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   load_vld,
  output logic                   load_rdy,
  input  logic [DIM*BITS_AB-1:0] load_row,
  input  logic                   start,
  output logic                   full,
  output logic                   out_vld,
  output logic [DIM*BITS_AB-1:0] a_out,
  output logic                   done
);

  localparam int c_rw = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int c_tw = $clog2(2*DIM-1);
  localparam int c_w  = DIM*BITS_AB;
  localparam logic [c_rw-1:0] c_last_row = c_rw'(DIM-1);
  localparam logic [c_tw-1:0] c_last_t   = c_tw'(2*DIM-2);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_FULL   = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [c_w-1:0]  r_mem [DIM];
  logic [c_rw-1:0] r_row_cnt;
  logic [c_tw-1:0] r_t_cnt;
  logic [c_w-1:0]  r_a_out;
  logic            r_out_vld;
  logic            r_done;
  logic            r_drain;
  logic [c_w-1:0]  w_skew;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY:  if (load_vld && r_row_cnt == c_last_row) w_state_nxt = ST_FULL;
      ST_FULL:   if (start) w_state_nxt = ST_STREAM;
      ST_STREAM: if (en && r_t_cnt == c_last_t) w_state_nxt = ST_EMPTY;
      default:   w_state_nxt = ST_EMPTY;
    endcase
  end

  // Lane i sits on anti-diagonal t_cnt: column (or row when transposed) t_cnt-i.
  always_comb begin
    w_skew = '0;
    for (int i = 0; i < DIM; i++) begin
      for (int c = 0; c < DIM; c++) begin
        if (int'(r_t_cnt) == i + c) begin
`ifdef TPU_SKEW_TRANSPOSE_EN
          w_skew[i*BITS_AB +: BITS_AB] = r_mem[c][i*BITS_AB +: BITS_AB];
`else
          w_skew[i*BITS_AB +: BITS_AB] = r_mem[i][c*BITS_AB +: BITS_AB];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DIM; r++) r_mem[r] <= '0;
      r_row_cnt <= '0;
      r_t_cnt   <= '0;
      r_a_out   <= '0;
      r_out_vld <= 1'b0;
      r_done    <= 1'b0;
      r_drain   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // The closing done pulse waits for the first enabled edge after the stream.
      if (r_drain && en) begin
        r_a_out   <= '0;
        r_out_vld <= 1'b0;
        r_done    <= 1'b1;
        r_drain   <= 1'b0;
      end
      case (r_state)
        ST_EMPTY: begin
          if (load_vld) begin
            r_mem[r_row_cnt] <= load_row;
            r_row_cnt        <= (r_row_cnt == c_last_row) ? '0 : r_row_cnt + 1'b1;
          end
        end
        ST_FULL: begin
          if (start) r_t_cnt <= '0;
        end
        ST_STREAM: begin
          if (en) begin
            r_a_out   <= w_skew;
            r_out_vld <= 1'b1;
            if (r_t_cnt == c_last_t) begin
              r_t_cnt <= '0;
              r_drain <= 1'b1;
            end else begin
              r_t_cnt <= r_t_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign load_rdy = (r_state == ST_EMPTY);
  assign full     = (r_state == ST_FULL);
  assign out_vld  = r_out_vld;
  assign a_out    = r_a_out;
  assign done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_tpu_skew_feeder.sv
// ============================================================================
//  Module   : tb_tpu_skew_feeder
//  Brief    : Randomized self-checking bench for tpu_skew_feeder (DIM=4, 8-bit),
//             honours TPU_SKEW_TRANSPOSE_EN in its reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tpu_skew_feeder;

  localparam int DIM  = 4;
  localparam int BITS = 8;
  localparam int W    = DIM*BITS;
  localparam int LEN  = 2*DIM-1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         load_vld;
  logic         start;
  logic [W-1:0] load_row;
  logic         load_rdy;
  logic         full;
  logic         out_vld;
  logic         done;
  logic [W-1:0] a_out;

  logic [BITS-1:0] m [DIM][DIM];
  int n_checks = 0;
  int n_pass   = 0;

  tpu_skew_feeder #(.BITS_AB(BITS), .DIM(DIM)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load_vld(load_vld), .load_rdy(load_rdy),
    .load_row(load_row), .start(start), .full(full), .out_vld(out_vld),
    .a_out(a_out), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Anti-diagonal t of the matrix as the array edge should see it.
  function automatic logic [W-1:0] exp_lanes(input int t);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < DIM; i++) begin
      int k;
      k = t - i;
      if (k >= 0 && k < DIM) begin
`ifdef TPU_SKEW_TRANSPOSE_EN
        v[i*BITS +: BITS] = m[k][i];
`else
        v[i*BITS +: BITS] = m[i][k];
`endif
      end
    end
    return v;
  endfunction

  task automatic load_matrix(input bit fixed, input bit start_on_last);
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        m[r][c] = fixed ? BITS'(16*r + c) : BITS'($urandom);
        load_row[c*BITS +: BITS] = m[r][c];
      end
      load_vld = 1'b1;
      start    = start_on_last && (r == DIM-1);
      tick();
      check($sformatf("load_rdy_r%0d", r), 64'(load_rdy), 64'(r < DIM-1));
      check($sformatf("full_r%0d", r), 64'(full), 64'(r == DIM-1));
    end
    load_vld = 1'b0;
    start    = 1'b0;
  endtask

  // Streams the stored matrix; returns early (with rst_n low) if abort_at is hit.
  task automatic run_stream(input int stall_at, input bit rand_en, input int abort_at);
    int t, cyc, stall_left;
    bit fin, en_now;
    logic [W-1:0] pa, ex;
    logic pv;
    t = 0; cyc = 0; stall_left = 3; fin = 0; pa = '0; pv = 1'b0;
    en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check("start_edge_vld", 64'(out_vld), 64'd0);
    while (!fin && cyc < 200) begin
      if (rand_en) en_now = ($urandom_range(0, 3) != 0);
      else if (stall_at >= 0 && t == stall_at + 1 && stall_left > 0) begin
        en_now = 1'b0;
        stall_left--;
      end else en_now = 1'b1;
      en = en_now;
      tick();
      cyc++;
      if (!en_now) begin
        check($sformatf("hold_t%0d", t), {30'd0, done, pv, a_out}, {30'd0, 1'b0, out_vld, pa});
        check($sformatf("hold_a_t%0d", t), 64'(a_out), 64'(pa));
        check($sformatf("hold_v_t%0d", t), 64'(out_vld), 64'(pv));
      end else if (t < LEN) begin
        ex = exp_lanes(t);
        check($sformatf("skew_t%0d", t), {30'd0, done, out_vld, a_out}, {30'd0, 1'b0, 1'b1, ex});
        pa = ex; pv = 1'b1;
        if (t == abort_at) begin
          #2 rst_n = 1'b0;
          #1;
          check("abort_outputs", {29'd0, done, out_vld, full, a_out}, 64'd0);
          check("abort_load_rdy", 64'(load_rdy), 64'd1);
          return;
        end
        t++;
      end else begin
        check("done_pulse", {30'd0, done, out_vld, a_out}, {30'd0, 1'b1, 1'b0, 32'd0});
        fin = 1;
      end
    end
    if (!fin) check("stream_timeout", 64'd0, 64'd1);
    en = 1'b1;
    tick();
    check("after_done", {30'd0, done, out_vld, a_out}, 64'd0);
    check("after_done_rdy", 64'(load_rdy), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; load_vld = 1'b0; start = 1'b0; load_row = '0;
    #12;
    check("rst_outputs", {29'd0, done, out_vld, full, a_out}, 64'd0);
    check("rst_load_rdy", 64'(load_rdy), 64'd1);
    @(negedge clk) rst_n = 1'b1;

    // start while EMPTY is ignored
    en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("empty_start_vld", 64'(out_vld), 64'd0);
    check("empty_start_rdy", 64'(load_rdy), 64'd1);

    // fixed matrix, a fifth load must not disturb storage
    load_matrix(1'b1, 1'b0);
    load_vld = 1'b1; load_row = '1;
    tick();
    load_vld = 1'b0;
    check("fifth_load_full", 64'(full), 64'd1);
    run_stream(2, 1'b0, -1);

    // start coinciding with the last row write is ignored
    load_matrix(1'b1, 1'b1);
    repeat (3) begin
      tick();
      check("late_start_vld", 64'(out_vld), 64'd0);
      check("late_start_full", 64'(full), 64'd1);
    end
    run_stream(-1, 1'b0, -1);

    // reset mid-stream
    load_matrix(1'b1, 1'b0);
    run_stream(-1, 1'b0, 4);
    @(negedge clk) rst_n = 1'b1;
    en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) begin
      tick();
      check("post_abort_vld", 64'(out_vld), 64'd0);
      check("post_abort_rdy", 64'(load_rdy), 64'd1);
    end

    // randomized matrices with random enable
    for (int k = 0; k < 6; k++) begin
      load_matrix(1'b0, 1'b0);
      run_stream(-1, 1'b1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
